hbridge_deadtime: RTL and testbench



---
 rtl/bldc_pkg.sv | 22 ++
 rtl/deadtime_leg.sv | 97 +++++++++
 rtl/hbridge_deadtime.sv | 81 ++++++++
 tb/tb_hbridge_deadtime.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// Shared types and bit-mapping helpers for the BLDC output stage.
package bldc_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        ON_H = 2'd1,
        ON_L = 2'd2,
        DEAD = 2'd3
    } leg_state_e;

    localparam int N_PHASES     = 3;
    localparam int FAULT_OC_BIT = 3;

    function automatic int IDX_H(input int k);
        return 2 * k;
    endfunction

    function automatic int IDX_L(input int k);
        return 2 * k + 1;
    endfunction

endpackage

// File: rtl/deadtime_leg.sv
// One half-bridge leg: complementary gate FSM with dead-time insertion.
module deadtime_leg
    import bldc_pkg::*;
#(
    parameter int DEADTIME = 2,
    parameter int CNT_W    = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_h,
    input  logic req_l,
    input  logic force_dead,
    output logic gate_h,
    output logic gate_l
);

    generate
        if (DEADTIME < 1 || DEADTIME > (2 ** CNT_W) - 1) begin : g_bad_deadtime
            $error("deadtime_leg: DEADTIME out of range");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEADTIME - 1);

    leg_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             gate_h_reg, gate_h_next;
    logic             gate_l_reg, gate_l_next;
    logic             only_h, only_l;

    assign only_h = req_h & ~req_l;
    assign only_l = req_l & ~req_h;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg  <= OFF;
            cnt_reg    <= '0;
            gate_h_reg <= 1'b0;
            gate_l_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            gate_h_reg <= gate_h_next;
            gate_l_reg <= gate_l_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (force_dead) begin
            // Holding the counter at 0 guarantees a full dead time after release.
            state_next = DEAD;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                OFF: begin
                    if (only_h)      state_next = ON_H;
                    else if (only_l) state_next = ON_L;
                end
                ON_H: begin
                    if (!only_h) begin
                        state_next = DEAD;
                        cnt_next   = '0;
                    end
                end
                ON_L: begin
                    if (!only_l) begin
                        state_next = DEAD;
                        cnt_next   = '0;
                    end
                end
                DEAD: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next = '0;
                        if (only_h)      state_next = ON_H;
                        else if (only_l) state_next = ON_L;
                        else             state_next = OFF;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: state_next = OFF;
            endcase
        end
    end

    // Gates are registered from the next state so they track the FSM with no extra lag.
    always_comb begin
        gate_h_next = (state_next == ON_H);
        gate_l_next = (state_next == ON_L);
    end

    assign gate_h = gate_h_reg;
    assign gate_l = gate_l_reg;

endmodule

// File: rtl/hbridge_deadtime.sv
// Three-leg gate driver stage with dead time, shoot-through blocking and fault latch.
module hbridge_deadtime
    import bldc_pkg::*;
#(
    parameter int DEADTIME = 2,
    parameter int CNT_W    = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [5:0] hbridge_i,
    input  logic       overcurrent_i,
    input  logic       clear_fault_i,
    output logic [5:0] gate_o,
    output logic       fault_o,
    output logic [3:0] fault_cause_o
);

    logic [N_PHASES:0] src;
    logic              src_any;
    logic              force_dead;
    logic              fault_reg, fault_next;
    logic [3:0]        cause_reg, cause_next;
    logic [5:0]        gate_w;

    assign src[FAULT_OC_BIT] = overcurrent_i;
    assign src_any           = |src;
    // Live sources force the legs in the same cycle so gates drop on the next edge.
    assign force_dead        = ~enable_i | fault_reg | src_any;

    generate
        for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_leg
            assign src[gi] = enable_i & hbridge_i[IDX_H(gi)] & hbridge_i[IDX_L(gi)];

            deadtime_leg #(
                .DEADTIME (DEADTIME),
                .CNT_W    (CNT_W)
            ) u_leg (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .req_h      (hbridge_i[IDX_H(gi)]),
                .req_l      (hbridge_i[IDX_L(gi)]),
                .force_dead (force_dead),
                .gate_h     (gate_w[IDX_H(gi)]),
                .gate_l     (gate_w[IDX_L(gi)])
            );

            always_ff @(posedge clk_i) begin
                assert (!(gate_w[IDX_H(gi)] && gate_w[IDX_L(gi)]))
                    else $error("hbridge_deadtime: both gates on in leg %0d", gi);
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fault_reg <= 1'b0;
            cause_reg <= '0;
        end else begin
            fault_reg <= fault_next;
            cause_reg <= cause_next;
        end
    end

    always_comb begin
        fault_next = fault_reg;
        cause_next = cause_reg;
        if (src_any) begin
            fault_next = 1'b1;
            cause_next = clear_fault_i ? src : (cause_reg | src);
        end else if (clear_fault_i) begin
            fault_next = 1'b0;
            cause_next = '0;
        end
    end

    assign gate_o        = gate_w;
    assign fault_o       = fault_reg;
    assign fault_cause_o = cause_reg;

endmodule

// File: tb/tb_hbridge_deadtime.sv
// Directed scenarios plus a randomized stream checked against a cycle-indexed reference model.
module tb_hbridge_deadtime;

    localparam int DT = 2;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       enable_i;
    logic [5:0] hbridge_i;
    logic       overcurrent_i;
    logic       clear_fault_i;
    logic [5:0] gate_o;
    logic       fault_o;
    logic [3:0] fault_cause_o;

    int total = 0;
    int bad   = 0;

    // Reference model: per leg the driven side (0 none, 1 high, 2 low), whether
    // the leg is in a dead interval, and the cycle index at which it may decide.
    int         m_side   [3];
    bit         m_dead   [3];
    int         m_resume [3];
    bit         m_fault;
    logic [3:0] m_cause;
    int         cyc = 0;

    hbridge_deadtime #(
        .DEADTIME (DT),
        .CNT_W    (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .hbridge_i     (hbridge_i),
        .overcurrent_i (overcurrent_i),
        .clear_fault_i (clear_fault_i),
        .gate_o        (gate_o),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [5:0] model_gates();
        logic [5:0] g = '0;
        for (int k = 0; k < 3; k++) begin
            if (m_side[k] == 1) g[2*k]   = 1'b1;
            if (m_side[k] == 2) g[2*k+1] = 1'b1;
        end
        return g;
    endfunction

    task automatic model_update(input logic rst, input logic en, input logic [5:0] hb,
                                input logic oc, input logic clr);
        logic [3:0] src;
        bit         force_all;
        int         req;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                m_side[k] = 0; m_dead[k] = 0; m_resume[k] = 0;
            end
            m_fault = 0;
            m_cause = '0;
            return;
        end
        for (int k = 0; k < 3; k++) src[k] = en & hb[2*k] & hb[2*k+1];
        src[3] = oc;
        force_all = !en || m_fault || (src != 4'b0);
        for (int k = 0; k < 3; k++) begin
            req = (hb[2*k] && !hb[2*k+1]) ? 1 : (hb[2*k+1] && !hb[2*k]) ? 2 : 0;
            if (force_all) begin
                m_side[k] = 0; m_dead[k] = 1; m_resume[k] = cyc + DT;
            end else if (m_side[k] != 0) begin
                if (req != m_side[k]) begin
                    m_side[k] = 0; m_dead[k] = 1; m_resume[k] = cyc + DT;
                end
            end else if (m_dead[k]) begin
                if (cyc == m_resume[k]) begin
                    m_side[k] = req; m_dead[k] = 0;
                end
            end else begin
                m_side[k] = req;
            end
        end
        if (src != 4'b0) begin
            m_fault = 1;
            m_cause = clr ? src : (m_cause | src);
        end else if (clr) begin
            m_fault = 0;
            m_cause = '0;
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [5:0] hb,
                        input logic oc, input logic clr);
        rst_ni        = rst;
        enable_i      = en;
        hbridge_i     = hb;
        overcurrent_i = oc;
        clear_fault_i = clr;
        @(posedge clk_i);
        #1;
        model_update(rst, en, hb, oc, clr);
        cyc++;
        $display("cyc=%0d rst_n=%b en=%b hb=%b oc=%b clr=%b -> gate=%b fault=%b cause=%b",
                 cyc, rst, en, hb, oc, clr, gate_o, fault_o, fault_cause_o);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 6'b000000, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b0) begin bad++; $display("FAIL reset_gate got=%b want=%b", gate_o, 6'b0); end
        total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fault_o); end
        total++; if (fault_cause_o !== 4'b0) begin bad++; $display("FAIL reset_cause got=%b want=0000", fault_cause_o); end
        step(1'b1, 1'b1, 6'b000001, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b000001) begin bad++; $display("FAIL first_on got=%b want=000001", gate_o); end
        total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL first_on_fault got=%b want=0", fault_o); end
    endtask

    task automatic test_commutation();
        step(1'b1, 1'b1, 6'b000010, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b000000) begin bad++; $display("FAIL comm_n1 got=%b want=000000", gate_o); end
        step(1'b1, 1'b1, 6'b000010, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b000000) begin bad++; $display("FAIL comm_n2 got=%b want=000000", gate_o); end
        step(1'b1, 1'b1, 6'b000010, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b000010) begin bad++; $display("FAIL comm_n3 got=%b want=000010", gate_o); end
    endtask

    task automatic test_shoot_through();
        step(1'b1, 1'b1, 6'b001100, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b0) begin bad++; $display("FAIL st_gate got=%b want=000000", gate_o); end
        total++; if (fault_o !== 1'b1) begin bad++; $display("FAIL st_fault got=%b want=1", fault_o); end
        total++; if (fault_cause_o !== 4'b0010) begin bad++; $display("FAIL st_cause got=%b want=0010", fault_cause_o); end
        step(1'b1, 1'b1, 6'b001100, 1'b0, 1'b1);
        total++; if (fault_o !== 1'b1) begin bad++; $display("FAIL st_clear_blocked got=%b want=1", fault_o); end
        total++; if (fault_cause_o !== 4'b0010) begin bad++; $display("FAIL st_clear_cause got=%b want=0010", fault_cause_o); end
        step(1'b1, 1'b1, 6'b000100, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b0) begin bad++; $display("FAIL st_latched_gate got=%b want=000000", gate_o); end
        step(1'b1, 1'b1, 6'b000100, 1'b0, 1'b1);
        total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL st_cleared got=%b want=0", fault_o); end
        total++; if (fault_cause_o !== 4'b0) begin bad++; $display("FAIL st_cleared_cause got=%b want=0000", fault_cause_o); end
        step(1'b1, 1'b1, 6'b000100, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b0) begin bad++; $display("FAIL st_release_dead got=%b want=000000", gate_o); end
        step(1'b1, 1'b1, 6'b000100, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b000100) begin bad++; $display("FAIL st_release_on got=%b want=000100", gate_o); end
    endtask

    task automatic test_overcurrent();
        step(1'b1, 1'b1, 6'b100000, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b100000) begin bad++; $display("FAIL oc_leg2_low got=%b want=100000", gate_o); end
        step(1'b1, 1'b1, 6'b100000, 1'b1, 1'b0);
        total++; if (gate_o !== 6'b0) begin bad++; $display("FAIL oc_gate got=%b want=000000", gate_o); end
        total++; if (fault_cause_o !== 4'b1000) begin bad++; $display("FAIL oc_cause got=%b want=1000", fault_cause_o); end
        step(1'b1, 1'b1, 6'b100000, 1'b1, 1'b1);
        total++; if (fault_o !== 1'b1) begin bad++; $display("FAIL oc_clear_blocked got=%b want=1", fault_o); end
        step(1'b1, 1'b1, 6'b000000, 1'b0, 1'b1);
        total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL oc_cleared got=%b want=0", fault_o); end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 6'b000000, 1'b0, 1'b0);
    endtask

    task automatic test_enable();
        step(1'b1, 1'b1, 6'b000001, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b000001) begin bad++; $display("FAIL en_on got=%b want=000001", gate_o); end
        step(1'b1, 1'b1, 6'b000010, 1'b0, 1'b0);
        step(1'b1, 1'b0, 6'b000011, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b0) begin bad++; $display("FAIL en_off_gate got=%b want=000000", gate_o); end
        total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL en_off_no_st got=%b want=0", fault_o); end
        step(1'b1, 1'b0, 6'b000010, 1'b0, 1'b0);
        step(1'b1, 1'b1, 6'b000010, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b0) begin bad++; $display("FAIL en_restore_dead got=%b want=000000", gate_o); end
        step(1'b1, 1'b1, 6'b000010, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b000010) begin bad++; $display("FAIL en_restore_on got=%b want=000010", gate_o); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 6'b000001, 1'b0, 1'b0);
        step(1'b1, 1'b1, 6'b000001, 1'b1, 1'b0);
        total++; if (fault_o !== 1'b1) begin bad++; $display("FAIL rm_fault_set got=%b want=1", fault_o); end
        step(1'b0, 1'b1, 6'b000001, 1'b0, 1'b0);
        total++; if ({gate_o, fault_o, fault_cause_o} !== 11'b0) begin
            bad++; $display("FAIL rm_reset got=%b/%b/%b want=0", gate_o, fault_o, fault_cause_o);
        end
        step(1'b1, 1'b1, 6'b000001, 1'b0, 1'b0);
        total++; if (gate_o !== 6'b000001) begin bad++; $display("FAIL rm_first_on got=%b want=000001", gate_o); end
    endtask

    task automatic test_random();
        logic [5:0] hb = '0;
        logic       rst, en, oc, clr;
        int         r;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < 3; k++) begin
                    r = $urandom_range(0, 15);
                    hb[2*k +: 2] = (r < 6) ? 2'b00 : (r < 11) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
                end
            end
            rst = ($urandom_range(0, 199) != 0);
            en  = ($urandom_range(0, 19) != 0);
            oc  = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 7) == 0);
            step(rst, en, hb, oc, clr);
            total++; if (gate_o !== model_gates()) begin
                bad++; $display("FAIL rnd_gate cyc=%0d got=%b want=%b", cyc, gate_o, model_gates());
            end
            total++; if (fault_o !== m_fault) begin
                bad++; $display("FAIL rnd_fault cyc=%0d got=%b want=%b", cyc, fault_o, m_fault);
            end
            total++; if (fault_cause_o !== m_cause) begin
                bad++; $display("FAIL rnd_cause cyc=%0d got=%b want=%b", cyc, fault_cause_o, m_cause);
            end
            for (int k = 0; k < 3; k++) begin
                total++; if ((gate_o[2*k] & gate_o[2*k+1]) !== 1'b0) begin
                    bad++; $display("FAIL rnd_overlap cyc=%0d leg=%0d got=%b want=00", cyc, k, gate_o[2*k +: 2]);
                end
            end
        end
    endtask

    initial begin
        rst_ni        = 1'b0;
        enable_i      = 1'b0;
        hbridge_i     = '0;
        overcurrent_i = 1'b0;
        clear_fault_i = 1'b0;
        test_reset();
        test_commutation();
        test_shoot_through();
        test_overcurrent();
        test_enable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
